alu_vector_sequencer: RTL

// - Self-test controller for the 16-bit Hack-style ALU and its two 32-entry operand banks.
// - Each test vector is one (operand address pair, ALU control word) combination.
// - Walks all 18 Hack ALU functions across every operand address, driving address_a/address_b and zx..no.
// - Folds each result into a 16-bit signature and counts zr/ng flags; sits between board switches and ALU top level.

---
 rtl/alu_vector_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_vector_sequencer.sv
//------------------------------------------------------------------------------
// alu_vector_sequencer
//
// Self-test controller for a 16-bit Hack-style ALU fed by two 32-entry operand
// banks. It walks every one of the 18 Hack ALU functions across every operand
// address. For each vector it drives the bank addresses and the ALU control
// word. It then folds the ALU result into a 16-bit signature and counts how
// many results raised the zero and negative flags.
//
// Vector order: op_idx is the outer loop and a_idx is the inner loop.
// Each vector takes two cycles: SETTLE (operand read and ALU settle) followed
// by SAMPLE (fold the result).
//
// Optional build feature (macro STEP_MODE_EN):
//   When defined, the block adds a 'step' input. SETTLE then waits for step=1
//   before it moves to SAMPLE, so one step pulse runs one vector.
//   When undefined, SETTLE always lasts exactly one cycle.
//
// Parameters:
//   ADDR_W    operand address width (2^ADDR_W entries per bank)
//   DATA_W    ALU data width (signature taps are laid out for 16)
//   B_OFFSET  address_b = (address_a + B_OFFSET) mod 2^ADDR_W
//   EXP_SIG   golden signature that drives 'pass'
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   level; starts a run from IDLE or DONE (ignored while busy)
//   abort      in   returns to IDLE from any state; has priority over start
//   step       in   (STEP_MODE_EN only) lets SETTLE advance to SAMPLE
//   alu_out    in   ALU result
//   alu_zr     in   ALU zero flag
//   alu_ng     in   ALU negative flag
//   address_a  out  operand bank A address (registered)
//   address_b  out  operand bank B address (registered)
//   ctrl       out  {zx,nx,zy,ny,f,no} (registered)
//   busy       out  high in SETTLE/SAMPLE
//   done       out  high in DONE
//   pass       out  done && signature == EXP_SIG
//   signature  out  running result signature
//   zr_count   out  number of vectors with alu_zr=1
//   ng_count   out  number of vectors with alu_ng=1
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module alu_vector_sequencer #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 16,
  parameter int                B_OFFSET = 1,
  parameter logic [DATA_W-1:0] EXP_SIG  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
`ifdef STEP_MODE_EN
  input  logic              step,
`endif
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] address_a,
  output logic [ADDR_W-1:0] address_b,
  output logic [5:0]        ctrl,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] signature,
  output logic [9:0]        zr_count,
  output logic [9:0]        ng_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [4:0]        LAST_OP = 5'd17;
  localparam logic [ADDR_W-1:0] LAST_A  = '1;
  localparam logic [ADDR_W-1:0] B_OFF   = ADDR_W'(B_OFFSET);

  // Hack ALU function table, indexed by op_idx.
  function automatic logic [5:0] op_ctrl(input logic [4:0] idx);
    case (idx)
      5'd0:    op_ctrl = 6'b101010;  // 0
      5'd1:    op_ctrl = 6'b111111;  // 1
      5'd2:    op_ctrl = 6'b111010;  // -1
      5'd3:    op_ctrl = 6'b001100;  // x
      5'd4:    op_ctrl = 6'b110000;  // y
      5'd5:    op_ctrl = 6'b001101;  // !x
      5'd6:    op_ctrl = 6'b110001;  // !y
      5'd7:    op_ctrl = 6'b001111;  // -x
      5'd8:    op_ctrl = 6'b110011;  // -y
      5'd9:    op_ctrl = 6'b011111;  // x+1
      5'd10:   op_ctrl = 6'b110111;  // y+1
      5'd11:   op_ctrl = 6'b001110;  // x-1
      5'd12:   op_ctrl = 6'b110010;  // y-1
      5'd13:   op_ctrl = 6'b000010;  // x+y
      5'd14:   op_ctrl = 6'b010011;  // x-y
      5'd15:   op_ctrl = 6'b000111;  // y-x
      5'd16:   op_ctrl = 6'b000000;  // x&y
      5'd17:   op_ctrl = 6'b010101;  // x|y
      default: op_ctrl = 6'b101010;
    endcase
  endfunction

  state_t              state_reg, state_next;
  logic [4:0]          op_idx_reg;
  logic [ADDR_W-1:0]   a_idx_reg;
  logic [ADDR_W-1:0]   addr_b_reg;
  logic [5:0]          ctrl_reg;
  logic [DATA_W-1:0]   sig_reg;
  logic [9:0]          zr_reg;
  logic [9:0]          ng_reg;

  // Control decodes shared by the FSM and the datapath.
  logic              settle_go;
  logic              last_vec;
  logic              run_start;
  logic              do_sample;
  logic [ADDR_W-1:0] a_idx_adv;
  logic [4:0]        op_idx_adv;
  logic              sig_fb;
  logic [DATA_W-1:0] sig_fold;

`ifdef STEP_MODE_EN
  assign settle_go = step;
`else
  assign settle_go = 1'b1;
`endif

  assign last_vec  = (op_idx_reg == LAST_OP) && (a_idx_reg == LAST_A);
  // abort wins over everything, so neither a fresh start nor a fold may
  // happen on an abort edge.
  assign run_start = !abort && start && ((state_reg == IDLE) || (state_reg == DONE));
  assign do_sample = !abort && (state_reg == SAMPLE);

  // The inner address wraps naturally at 2^ADDR_W, and the carry steps the op.
  assign a_idx_adv  = a_idx_reg + 1'b1;
  assign op_idx_adv = (a_idx_reg == LAST_A) ? (op_idx_reg + 5'd1) : op_idx_reg;

  // Signature: shift left with the feedback bit in bit 0, then XOR in the result.
  assign sig_fb   = sig_reg[DATA_W-1] ^ sig_reg[DATA_W-2] ^ sig_reg[DATA_W-4] ^ sig_reg[3];
  assign sig_fold = {sig_reg[DATA_W-2:0], sig_fb} ^ alu_out;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = SETTLE;
        SETTLE:  if (settle_go) state_next = SAMPLE;
        SAMPLE:  state_next = last_vec ? DONE : SETTLE;
        DONE:    if (start) state_next = SETTLE;
        default: state_next = IDLE;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      SETTLE, SAMPLE: busy = 1'b1;
      DONE:           done = 1'b1;
      default:        ;
    endcase
    pass = done && (sig_reg == EXP_SIG);
  end

  //--------------------------------------------------------------------------
  // Vector indices and registered drive outputs. address_b and ctrl are
  // computed from the *next* index values, so all three drive outputs change
  // together on the SAMPLE edge. This keeps them stable through the following
  // SETTLE cycle. The last vector does not advance, so DONE holds the final
  // addresses.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_idx_reg  <= '0;
      op_idx_reg <= 5'd0;
      addr_b_reg <= B_OFF;
      ctrl_reg   <= op_ctrl(5'd0);
    end else if (abort || run_start) begin
      a_idx_reg  <= '0;
      op_idx_reg <= 5'd0;
      addr_b_reg <= B_OFF;
      ctrl_reg   <= op_ctrl(5'd0);
    end else if (do_sample && !last_vec) begin
      a_idx_reg  <= a_idx_adv;
      op_idx_reg <= op_idx_adv;
      addr_b_reg <= a_idx_adv + B_OFF;
      ctrl_reg   <= op_ctrl(op_idx_adv);
    end
  end

  //--------------------------------------------------------------------------
  // Signature and flag counters. They are cleared only by reset or a new run.
  // An abort leaves them intact so that the partial result can be inspected.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_reg <= '0;
      zr_reg  <= 10'd0;
      ng_reg  <= 10'd0;
    end else if (run_start) begin
      sig_reg <= '0;
      zr_reg  <= 10'd0;
      ng_reg  <= 10'd0;
    end else if (do_sample) begin
      sig_reg <= sig_fold;
      zr_reg  <= zr_reg + 10'(alu_zr);
      ng_reg  <= ng_reg + 10'(alu_ng);
    end
  end

  assign address_a = a_idx_reg;
  assign address_b = addr_b_reg;
  assign ctrl      = ctrl_reg;
  assign signature = sig_reg;
  assign zr_count  = zr_reg;
  assign ng_count  = ng_reg;

endmodule
